// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int unsigned RF_DW    = 32;
  localparam int unsigned RF_AW    = 5;
  localparam int unsigned RF_ENTRY = 32;
  localparam int unsigned RF_PW    = 2;

  typedef logic [RF_PW-1:0] cnt_t;

  // Low bit of port 'port' inside a flat bus of 'width'-bit fields.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned entries);
    return addr < entries;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-entry pending-write counters: alloc/release arithmetic, busy/full flags, sticky error.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned ENTRY   = RF_ENTRY,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter int unsigned PW      = RF_PW,
  parameter int unsigned ZREG_EN = 0,
  parameter int unsigned ZREG    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aen,
  input  logic [AW-1:0]     aa,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NRD*AW-1:0] ra,
  output logic [NWR-1:0]    wacc,
  output logic [NRD-1:0]    rbusy,
  output logic              afull,
  output logic              err
);

  localparam logic [PW-1:0] CntMax = {PW{1'b1}};

  logic [PW-1:0] cnt_q [ENTRY];
  logic [PW-1:0] cnt_d [ENTRY];
  logic [AW-1:0] wa_s  [NWR];
  logic [AW-1:0] ra_s  [NRD];
  logic          inc   [ENTRY];
  logic          dec   [ENTRY];
  logic [NWR-1:0] wbad;
  logic [PW-1:0]  cnt_aa;
  logic           aa_ok, aa_zero, alloc_ok;
  logic           err_q;

  always_comb begin
    for (int unsigned k = 0; k < NWR; k++) begin
      wa_s[k] = wa[slice_lo(k, AW) +: AW];
      wbad[k] = wen[k] && !addr_ok(32'(wa_s[k]), ENTRY);
      // Writes to the hardwired-zero entry are dropped and never release a count.
      wacc[k] = wen[k] && !wbad[k] && !((ZREG_EN != 0) && (wa_s[k] == AW'(ZREG)));
    end
    for (int unsigned i = 0; i < NRD; i++) ra_s[i] = ra[slice_lo(i, AW) +: AW];
  end

  always_comb begin
    aa_ok   = addr_ok(32'(aa), ENTRY);
    aa_zero = (ZREG_EN != 0) && (aa == AW'(ZREG));
    cnt_aa  = '0;
    for (int unsigned e = 0; e < ENTRY; e++) if (aa == AW'(e)) cnt_aa = cnt_q[e];
    afull    = aa_ok && (cnt_aa == CntMax);
    alloc_ok = aen && aa_ok && !aa_zero && !afull;
  end

  always_comb begin
    for (int unsigned e = 0; e < ENTRY; e++) begin
      inc[e] = alloc_ok && (aa == AW'(e));
      dec[e] = 1'b0;
      for (int unsigned k = 0; k < NWR; k++) dec[e] = dec[e] | (wacc[k] && (wa_s[k] == AW'(e)));
      cnt_d[e] = cnt_q[e];
      if (inc[e] && !dec[e]) begin
        cnt_d[e] = cnt_q[e] + PW'(1);
      end else if (dec[e] && !inc[e] && (cnt_q[e] != '0)) begin
        cnt_d[e] = cnt_q[e] - PW'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      rbusy[i] = 1'b0;
      for (int unsigned e = 0; e < ENTRY; e++) begin
        if ((ra_s[i] == AW'(e)) && (cnt_q[e] != '0)) rbusy[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < ENTRY; e++) cnt_q[e] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | (aen && !aa_ok) | (aen && aa_ok && !aa_zero && afull) | (|wbad);
    end
  end

  assign err = err_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional bypass, hardwired-zero entry and a
// write-pending scoreboard so decode can detect RAW hazards.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned DW      = RF_DW,
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned ENTRY   = RF_ENTRY,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZREG_EN = 0,
  parameter int unsigned ZREG    = 0,
  parameter int unsigned PW      = RF_PW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] wa,
  input  logic [NWR*DW-1:0] di,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] dout,
  output logic [NRD-1:0]    rbusy,
  input  logic              aen,
  input  logic [AW-1:0]     aa,
  output logic              afull,
  output logic              err
);

  logic [AW-1:0]  wa_s  [NWR];
  logic [DW-1:0]  di_s  [NWR];
  logic [AW-1:0]  ra_s  [NRD];
  logic [DW-1:0]  rd_s  [NRD];
  logic [DW-1:0]  mem_q [ENTRY];
  logic [DW-1:0]  mem_d [ENTRY];
  logic [NWR-1:0] wacc;

  rf_scoreboard #(
    .AW      (AW),
    .ENTRY   (ENTRY),
    .NRD     (NRD),
    .NWR     (NWR),
    .PW      (PW),
    .ZREG_EN (ZREG_EN),
    .ZREG    (ZREG)
  ) u_sb (
    .clk   (clk),
    .rst_n (rst_n),
    .aen   (aen),
    .aa    (aa),
    .wen   (wen),
    .wa    (wa),
    .ra    (ra),
    .wacc  (wacc),
    .rbusy (rbusy),
    .afull (afull),
    .err   (err)
  );

  always_comb begin
    for (int unsigned k = 0; k < NWR; k++) begin
      wa_s[k] = wa[slice_lo(k, AW) +: AW];
      di_s[k] = di[slice_lo(k, DW) +: DW];
    end
    for (int unsigned i = 0; i < NRD; i++) ra_s[i] = ra[slice_lo(i, AW) +: AW];
  end

  // Ascending port scan: the highest-index matching port lands last and wins.
  always_comb begin
    for (int unsigned e = 0; e < ENTRY; e++) begin
      mem_d[e] = mem_q[e];
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wacc[k] && (wa_s[k] == AW'(e))) mem_d[e] = di_s[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < ENTRY; e++) mem_q[e] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Out-of-range addresses match no entry and read as zero.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_s[i] = '0;
      for (int unsigned e = 0; e < ENTRY; e++) if (ra_s[i] == AW'(e)) rd_s[i] = mem_q[e];
      if (BYPASS != 0) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wacc[k] && (wa_s[k] == ra_s[i])) rd_s[i] = di_s[k];
        end
      end
      if ((ZREG_EN != 0) && (ra_s[i] == AW'(ZREG))) rd_s[i] = '0;
      dout[slice_lo(i, DW) +: DW] = rd_s[i];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: two instances (bypass on/off) share stimulus.
module tb_regfile_mp;

  localparam int unsigned DW = 32, AW = 6, ENTRY = 32, NRD = 2, NWR = 2, PW = 2;

  localparam logic [5:0] MD0A = 6'd1, MD1A = 6'd2, MD0B = 6'd4;
  localparam logic [5:0] MRB = 6'd8, MAF = 6'd16, MER = 6'd32;

  typedef struct {
    string       name;
    logic [5:0]  mask;
    logic [31:0] d0a, d1a, d0b;
    logic [1:0]  rb;
    logic        af, er;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NWR-1:0]    wen;
  logic [NWR*AW-1:0] wa;
  logic [NWR*DW-1:0] di;
  logic [NRD*AW-1:0] ra;
  logic              aen;
  logic [AW-1:0]     aa;
  logic [NRD*DW-1:0] dout_a, dout_b;
  logic [NRD-1:0]    rbusy_a, rbusy_b;
  logic              afull_a, afull_b, err_a, err_b;

  exp_t q[$];
  exp_t cur;
  logic chk = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DW(DW), .AW(AW), .ENTRY(ENTRY), .NRD(NRD), .NWR(NWR),
    .BYPASS(1), .ZREG_EN(1), .ZREG(0), .PW(PW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wa(wa), .di(di), .ra(ra),
    .dout(dout_a), .rbusy(rbusy_a), .aen(aen), .aa(aa), .afull(afull_a), .err(err_a)
  );

  regfile_mp #(
    .DW(DW), .AW(AW), .ENTRY(ENTRY), .NRD(NRD), .NWR(NWR),
    .BYPASS(0), .ZREG_EN(1), .ZREG(0), .PW(PW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wa(wa), .di(di), .ra(ra),
    .dout(dout_b), .rbusy(rbusy_b), .aen(aen), .aa(aa), .afull(afull_b), .err(err_b)
  );

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
  endtask

  // Monitor: compares combinational outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk && (q.size() > 0)) begin
      cur = q.pop_front();
      if (cur.mask[0]) cmp(cur.name, "dout0_byp", dout_a[31:0], cur.d0a);
      if (cur.mask[1]) cmp(cur.name, "dout1_byp", dout_a[63:32], cur.d1a);
      if (cur.mask[2]) cmp(cur.name, "dout0_nobyp", dout_b[31:0], cur.d0b);
      if (cur.mask[3]) cmp(cur.name, "rbusy", 32'(rbusy_a), 32'(cur.rb));
      if (cur.mask[4]) cmp(cur.name, "afull", 32'(afull_a), 32'(cur.af));
      if (cur.mask[5]) cmp(cur.name, "err", 32'(err_a), 32'(cur.er));
    end
  end

  task automatic idle();
    wen = '0; wa = '0; di = '0; ra = '0; aen = 1'b0; aa = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wen[p] = 1'b1;
    wa[p*AW +: AW] = AW'(a);
    di[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    ra[p*AW +: AW] = AW'(a);
  endtask

  task automatic al(input int a);
    aen = 1'b1;
    aa = AW'(a);
  endtask

  task automatic expect_out(input string nm, input logic [5:0] m, input logic [31:0] d0a,
                            input logic [31:0] d1a, input logic [31:0] d0b,
                            input logic [1:0] rb, input logic af, input logic er);
    exp_t e;
    e.name = nm; e.mask = m; e.d0a = d0a; e.d1a = d1a; e.d0b = d0b;
    e.rb = rb; e.af = af; e.er = er;
    q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state across all entries
    for (int r = 0; r < 32; r++) begin
      rd(0, r); rd(1, 31 - r);
      expect_out("rst_rd", MD0A | MD1A | MD0B | MRB | MAF | MER, 0, 0, 0, 2'b00, 1'b0, 1'b0);
      tick();
    end

    // Same-cycle write/read: bypass vs registered
    wr(0, 5, 32'hDEADBEEF); rd(0, 5);
    expect_out("r5_same", MD0A | MD0B | MRB | MER, 32'hDEADBEEF, 0, 0, 2'b00, 1'b0, 1'b0);
    tick();
    rd(0, 5);
    expect_out("r5_next", MD0A | MD0B, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0);
    tick();

    // Two-port collision on r7: port1 wins, count drops by one only
    al(7); tick();
    al(7); tick();
    rd(0, 7); aa = AW'(7);
    expect_out("r7_busy", MRB | MAF, 0, 0, 0, 2'b01, 1'b0, 1'b0);
    tick();
    wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); rd(0, 7);
    expect_out("r7_coll_same", MD0A | MD0B | MRB, 32'h2222, 0, 0, 2'b01, 1'b0, 1'b0);
    tick();
    rd(0, 7);
    expect_out("r7_coll_next", MD0A | MD0B | MRB, 32'h2222, 0, 32'h2222, 2'b01, 1'b0, 1'b0);
    tick();
    wr(0, 7, 32'h3333); tick();
    rd(0, 7);
    expect_out("r7_clear", MD0A | MRB, 32'h3333, 0, 0, 2'b00, 1'b0, 1'b0);
    tick();

    // Saturate r3, overflow alloc, then drain
    repeat (3) begin al(3); tick(); end
    rd(0, 3); aa = AW'(3);
    expect_out("r3_full", MRB | MAF | MER, 0, 0, 0, 2'b01, 1'b1, 1'b0);
    tick();
    al(3); rd(0, 3);
    expect_out("r3_over_same", MAF | MER, 0, 0, 0, 2'b00, 1'b1, 1'b0);
    tick();
    rd(0, 3); aa = AW'(3);
    expect_out("r3_over_next", MRB | MAF | MER, 0, 0, 0, 2'b01, 1'b1, 1'b1);
    tick();
    wr(0, 3, 32'h30); tick();
    wr(0, 3, 32'h31); tick();
    rd(0, 3); aa = AW'(3);
    expect_out("r3_two_wr", MRB | MAF, 0, 0, 0, 2'b01, 1'b0, 1'b1);
    tick();
    wr(0, 3, 32'h32); rd(0, 3);
    expect_out("r3_third_same", MD0A | MRB, 32'h32, 0, 0, 2'b01, 1'b0, 1'b1);
    tick();
    rd(0, 3); aa = AW'(3);
    expect_out("r3_done", MD0B | MRB | MAF, 0, 0, 32'h32, 2'b00, 1'b0, 1'b1);
    tick();

    // r9: alloc+write same cycle nets zero; write at cnt=0 does not underflow
    al(9); tick();
    al(9); wr(1, 9, 32'h99); tick();
    rd(0, 9); aa = AW'(9);
    expect_out("r9_net", MD0A | MRB | MAF, 32'h99, 0, 0, 2'b01, 1'b0, 1'b1);
    tick();
    wr(0, 9, 32'hA9); tick();
    wr(0, 9, 32'hB9); rd(0, 9);
    expect_out("r9_zero_wr", MRB, 0, 0, 0, 2'b00, 1'b0, 1'b1);
    tick();
    rd(0, 9); aa = AW'(9);
    expect_out("r9_no_uf", MD0A | MD0B | MRB | MAF, 32'hB9, 0, 32'hB9, 2'b00, 1'b0, 1'b1);
    tick();

    // Hardwired zero entry
    wr(0, 0, 32'h5); al(0); rd(0, 0); rd(1, 0);
    expect_out("z_same", MD0A | MD1A | MD0B | MRB | MAF, 0, 0, 0, 2'b00, 1'b0, 1'b1);
    tick();
    rd(0, 0); aa = AW'(0);
    expect_out("z_next", MD0A | MD0B | MRB | MAF, 0, 0, 0, 2'b00, 1'b0, 1'b1);
    tick();

    // Reset asserted mid-write clears data, counters and err
    wr(0, 12, 32'hAAAA); al(20); tick();
    rd(0, 12); rd(1, 20);
    expect_out("r12_pre", MD0A | MD0B | MRB | MER, 32'hAAAA, 0, 32'hAAAA, 2'b10, 1'b0, 1'b1);
    tick();
    wr(0, 12, 32'h5555); al(20);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    rd(0, 12); rd(1, 20); aa = AW'(20);
    expect_out("rst_mid", MD0A | MD1A | MD0B | MRB | MAF | MER, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    tick();

    // Out-of-range write: ignored (no aliasing onto r8), err set next cycle
    wr(1, 40, 32'h40); rd(0, 8); rd(1, 40);
    expect_out("oor_same", MD0A | MD1A | MER, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    tick();
    rd(0, 8); rd(1, 40); aa = AW'(40);
    expect_out("oor_next", MD0A | MD1A | MD0B | MAF | MER, 0, 0, 0, 2'b00, 1'b0, 1'b1);
    tick();

    cmp("drain", "queue_left", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
